scan_master: RTL

SCAN_MASTER -- requirements
Module: scan_master

---
 rtl/scan_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/scan_master.sv
// scan_master: serialises bytes into one of eight scan-chain pattern buffers while
// collecting the bits that fall out of the chain's far end, one byte at a time.
// Ports: clk/rst_n; start/addr/busy/done control; tx_* byte input handshake;
//        rx_* received-byte pulse; sclk/sin/ssel/saddr/sout scan bus to the buffers.
module scan_master #(
  parameter int BUFFER_SIZE  = 32,
  parameter int BUFFER_WIDTH = 8,
  parameter int CLKDIV       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              addr,
  output logic                    busy,
  output logic                    done,
  input  logic [BUFFER_WIDTH-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [BUFFER_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    sclk,
  output logic                    sin,
  output logic                    ssel,
  output logic [2:0]              saddr,
  input  logic                    sout
);

  localparam int BW = BUFFER_WIDTH;
  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, FINISH} state_t;

  state_t          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   byte_q, byte_d;
  logic [BW-1:0]   tx_sh_q, tx_sh_d;
  logic [BW-1:0]   rx_sh_q, rx_sh_d;
  logic [BW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            sclk_q, sclk_d;
  logic            ssel_q, ssel_d;
  logic [2:0]      saddr_q, saddr_d;
  logic            div_last;

  assign div_last = (div_q == 8'(CLKDIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      ssel_q     <= 1'b0;
      saddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      ssel_q     <= ssel_d;
      saddr_q    <= saddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = 1'b0;
    ssel_d     = ssel_q;
    saddr_d    = saddr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          saddr_d = addr;
          ssel_d  = 1'b1;
          byte_d  = '0;
          bit_d   = '0;
          div_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tx_valid) begin
          tx_sh_d = tx_data;
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          // sclk rises on this edge; capture the chain output at the same edge.
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[BW-2:0], sout};
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        sclk_d = 1'b1;
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'(BW - 1)) begin
            // Last bit: tx register is left alone so sin holds through LOAD.
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            byte_d     = byte_q + CW'(1);
            if (byte_d < CW'(BUFFER_SIZE)) begin
              state_d = LOAD;
            end else begin
              ssel_d  = 1'b0;
              state_d = FINISH;
            end
          end else begin
            tx_sh_d = {tx_sh_q[BW-2:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      FINISH: begin
        // Wait out the final rx_valid pulse so done never overlaps it.
        if (!rx_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH) && !rx_valid_q;
  assign tx_ready = (state_q == LOAD);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign sin      = tx_sh_q[BW-1];
  assign ssel     = ssel_q;
  assign saddr    = saddr_q;

endmodule
